frame_window_reader: RTL and testbench
======================================

# frame_window_reader

Parametrised frame-buffer read engine that pulls a rectangular window out of an INPUT_IMAGE_WIDTH×INPUT_IMAGE_HEIGHT frame in SDRAM and emits it as a marker-framed 17-bit pixel stream into the LCD-side store queue. It generalises the fixed-size read path of the video controller:
- The window origin and frame base are runtime inputs.
- Integer decimation is applied in X and Y.
- Window bounds are checked before any traffic is issued.

It sits between the SDRAM controller command port and the write side of the camera/LCD FIFO.

## Interface
Parameters:
- INPUT_IMAGE_WIDTH, 640: source line pitch in pixels.
- INPUT_IMAGE_HEIGHT, 480: source lines.
- OUTPUT_IMAGE_WIDTH, 23: emitted pixels per row.
- OUTPUT_IMAGE_HEIGHT, 17: emitted rows.
- STEP_X, 1: horizontal decimation (1..8).
- STEP_Y, 1: vertical decimation (1..8).
- BURST_WORDS, 8: 32-bit words per read burst. BURST_PIXELS = 2*BURST_WORDS.
- ADDR_WIDTH, 21: pixel address width.
- WATCHDOG_CYCLES, 1024: maximum wait for read data.

Ports:
- clk  in  1  single clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  SDRAM ready. start is ignored while low.
- start  in  1  one-cycle request to read one frame.
- frame_base_addr  in  ADDR_WIDTH  pixel address of source (0,0). Latched on start.
- win_x, win_y  in  16  window origin. Latched on start.
- busy  out  1  high from accepted start until the end marker is written.
- frame_done  out  1  one-cycle pulse after the end marker is written.
- error  out  1  sticky fault flag. Cleared by the next accepted start or by reset.
- cmd  out  1  memory command; 0 = read. Always 0.
- cmd_en  out  1  one-cycle command strobe.
- addr  out  ADDR_WIDTH  burst start address, valid with cmd_en.
- rd_data  in  32  read word. [15:0] is pixel at addr+2k; [31:16] is pixel at addr+2k+1.
- rd_data_valid  in  1  read word strobe.
- store_wr_en  out  1  queue write strobe.
- store_queue_full  in  1  queue full.
- store_queue_data  out  17  stream word.

## Operation
- Stream words:
  - 0x10000: frame start.
  - 0x10001: row start.
  - {1'b0, pixel}: pixel.
  - 0x1FFFF: frame end.
- Frame format: 0x10000; then OUTPUT_IMAGE_HEIGHT × (0x10001, OUTPUT_IMAGE_WIDTH pixels); then 0x1FFFF.
- Output pixel (j,i) = mem[frame_base_addr + (win_y + i*STEP_Y)*INPUT_IMAGE_WIDTH + win_x + j*STEP_X].
- Span per row: SPAN = (OUTPUT_IMAGE_WIDTH-1)*STEP_X + 1 pixels, fetched in ceil(SPAN/BURST_PIXELS) bursts.
- Burst k of a row is addressed at row_addr + k*BURST_PIXELS.
- Bounds check on start: reject if win_x + SPAN > INPUT_IMAGE_WIDTH or win_y + (OUTPUT_IMAGE_HEIGHT-1)*STEP_Y >= INPUT_IMAGE_HEIGHT. On reject: error=1, no cmd_en, no stream, stay IDLE.
- start while busy is ignored.
- States:
  - IDLE → FRAME_HDR on a valid start.
  - FRAME_HDR → ROW_HDR.
  - ROW_HDR → READ_CMD.
  - READ_CMD → READ_DATA.
  - READ_DATA → DRAIN after BURST_WORDS valid words.
  - DRAIN → READ_CMD if more bursts remain in the row.
  - DRAIN → ROW_HDR on row end with rows remaining.
  - DRAIN → FRAME_END after the last row.
  - FRAME_END → IDLE.
- Buffering:
  - READ_DATA stores words into a BURST_PIXELS local buffer.
  - DRAIN walks the buffer one slot per cycle.
  - A slot is written only if (slot offset from row start) % STEP_X == 0 and its index is < SPAN. Other slots consume one cycle with store_wr_en low.
- rd_data_valid outside READ_DATA sets error and is otherwise ignored.
- Address arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH. The row multiply is done once per row by accumulation (row_addr += STEP_Y*INPUT_IMAGE_WIDTH), not with a multiplier.

## Timing
- Reset values: busy=0, frame_done=0, error=0, cmd=0, cmd_en=0, addr=0, store_wr_en=0, store_queue_data=0, state IDLE.
- Start latency: start sampled high → busy high the next cycle. The frame-start marker is written on that cycle if the queue is not full.
- cmd_en is high for exactly one cycle in READ_CMD, with addr valid that cycle.
- rd_data_valid is accepted from the cycle after cmd_en onward. Any read latency is tolerated.
- DRAIN is entered the cycle after the last valid word.
- Queue writes:
  - store_wr_en is never asserted while store_queue_full is high.
  - A marker or pixel held back by full stays on store_queue_data and is written on the first cycle full is low.
  - The FSM does not advance past a held word.
- Back-to-back: with the queue never full, each row costs 1 + bursts*(1 + BURST_WORDS + BURST_PIXELS) cycles plus memory latency.
- Reset asserted mid-frame: all outputs return to reset values immediately, and any partial burst is discarded. After reset is released, rd_data_valid words are flagged as errors only once a start has been accepted.

## Configuration
- Macro FRAME_READER_WATCHDOG_EN, when defined:
  - A counter runs in READ_DATA and restarts on each rd_data_valid.
  - On reaching WATCHDOG_CYCLES with no valid word: error=1, busy drops, no end marker is written, return to IDLE.
- Without the macro: READ_DATA waits indefinitely and the counter logic is absent.

## Test plan
- Base 0x4B020, window (0,0), 23×17, STEP 1, random memory, queue never full → 0x10000, 17 × (0x10001 + 23 correct pixels), 0x1FFFF. Exactly 34 cmd_en (2 bursts/row). frame_done pulses once.
- STEP_X=2, STEP_Y=3, window (10,5) → pixel (j,i) = mem[base+(5+3i)*640+10+2j]. SPAN=45 → 3 bursts per row.
- store_queue_full toggled randomly at 50% → identical stream, no store_wr_en while full, no word lost or duplicated.
- win_x=620 with SPAN=23 → error=1 the cycle after start, zero cmd_en, zero stream writes. A following valid start clears error.
- Reset asserted during the 4th valid word of a burst, then a new start → all outputs zero during reset, then a correct complete frame.
- With FRAME_READER_WATCHDOG_EN and WATCHDOG_CYCLES=64, withhold rd_data_valid after cmd_en → error=1 after 64 cycles, busy=0, no 0x1FFFF written.

Source files
------------

// File: rtl/frame_window_reader.sv
// Frame-buffer window reader: bursts a decimated window out of SDRAM into a marker-framed stream.
// Optional read-data watchdog enabled by defining FRAME_READER_WATCHDOG_EN.
`timescale 1ns/1ps
module frame_window_reader #(
  parameter int unsigned INPUT_IMAGE_WIDTH   = 640,
  parameter int unsigned INPUT_IMAGE_HEIGHT  = 480,
  parameter int unsigned OUTPUT_IMAGE_WIDTH  = 23,
  parameter int unsigned OUTPUT_IMAGE_HEIGHT = 17,
  parameter int unsigned STEP_X              = 1,
  parameter int unsigned STEP_Y              = 1,
  parameter int unsigned BURST_WORDS         = 8,
  parameter int unsigned ADDR_WIDTH          = 21,
  parameter int unsigned WATCHDOG_CYCLES     = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_init_done,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_frame_base_addr,
  input  logic [15:0]           i_win_x,
  input  logic [15:0]           i_win_y,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_error,
  output logic                  o_cmd,
  output logic                  o_cmd_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic [31:0]           i_rd_data,
  input  logic                  i_rd_data_valid,
  output logic                  o_store_wr_en,
  input  logic                  i_store_queue_full,
  output logic [16:0]           o_store_queue_data
);

  localparam int unsigned BURST_PIXELS = 2 * BURST_WORDS;
  localparam int unsigned SPAN         = (OUTPUT_IMAGE_WIDTH - 1) * STEP_X + 1;
  localparam int unsigned NUM_BURSTS   = (SPAN + BURST_PIXELS - 1) / BURST_PIXELS;
  localparam int unsigned ROW_STRIDE   = STEP_Y * INPUT_IMAGE_WIDTH;
  localparam int unsigned Y_LAST       = (OUTPUT_IMAGE_HEIGHT - 1) * STEP_Y;
  localparam int unsigned SLOT_W       = $clog2(BURST_PIXELS);

  typedef enum logic [2:0] {
    StIdle, StFrameHdr, StRowHdr, StReadCmd, StReadData, StDrain, StFrameEnd
  } state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_row_addr, r_burst_addr;
  logic [15:0]           r_row_idx, r_burst_idx, r_off;
  logic [3:0]            r_phase;
  logic [SLOT_W-1:0]     r_wcnt, r_slot;
  logic                  r_error, r_armed, r_frame_done;
  logic [15:0]           r_buf [BURST_PIXELS];

  logic [31:0]           w_x_end, w_y_end;
  logic [ADDR_WIDTH-1:0] w_start_addr;
  logic [SLOT_W-1:0]     w_widx;
  logic                  w_oob, w_accept, w_go, w_full, w_pix_slot, w_slot_adv;
  logic                  w_last_slot, w_last_burst, w_last_row, w_rd_last, w_wd_timeout;

  assign w_x_end      = {16'd0, i_win_x} + SPAN;
  assign w_y_end      = {16'd0, i_win_y} + Y_LAST;
  assign w_oob        = (w_x_end > INPUT_IMAGE_WIDTH) || (w_y_end >= INPUT_IMAGE_HEIGHT);
  assign w_accept     = i_start && i_init_done && (r_state == StIdle);
  assign w_go         = w_accept && !w_oob;
  assign w_start_addr = i_frame_base_addr + ADDR_WIDTH'({16'd0, i_win_y} * INPUT_IMAGE_WIDTH)
                      + ADDR_WIDTH'(i_win_x);
  assign w_full       = i_store_queue_full;
  assign w_widx       = r_wcnt << 1;
  // Slot carries an output pixel only on the decimation grid and inside the row span.
  assign w_pix_slot   = (r_off < 16'(SPAN)) && (r_phase == 4'd0);
  assign w_slot_adv   = (r_state == StDrain) && (!w_pix_slot || !w_full);
  assign w_last_slot  = (r_slot == SLOT_W'(BURST_PIXELS - 1));
  assign w_last_burst = (r_burst_idx == 16'(NUM_BURSTS - 1));
  assign w_last_row   = (r_row_idx == 16'(OUTPUT_IMAGE_HEIGHT - 1));
  assign w_rd_last    = (r_state == StReadData) && i_rd_data_valid
                      && (r_wcnt == SLOT_W'(BURST_WORDS - 1));

`ifdef FRAME_READER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd <= '0;
    end else if ((r_state != StReadData) || i_rd_data_valid) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  assign w_wd_timeout = (r_state == StReadData) && !i_rd_data_valid
                      && (r_wd == WD_W'(WATCHDOG_CYCLES - 1));
`else
  assign w_wd_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    o_cmd_en           = 1'b0;
    o_addr             = '0;
    o_store_wr_en      = 1'b0;
    o_store_queue_data = '0;
    unique case (r_state)
      StIdle: if (w_go) w_state_next = StFrameHdr;
      StFrameHdr: begin
        o_store_queue_data = 17'h10000;
        o_store_wr_en      = !w_full;
        if (!w_full) w_state_next = StRowHdr;
      end
      StRowHdr: begin
        o_store_queue_data = 17'h10001;
        o_store_wr_en      = !w_full;
        if (!w_full) w_state_next = StReadCmd;
      end
      StReadCmd: begin
        o_cmd_en     = 1'b1;
        o_addr       = r_burst_addr;
        w_state_next = StReadData;
      end
      StReadData: begin
        if (w_rd_last)         w_state_next = StDrain;
        else if (w_wd_timeout) w_state_next = StIdle;
      end
      StDrain: begin
        if (w_pix_slot) begin
          o_store_queue_data = {1'b0, r_buf[r_slot]};
          o_store_wr_en      = !w_full;
        end
        if (w_slot_adv && w_last_slot) begin
          if (!w_last_burst)    w_state_next = StReadCmd;
          else if (!w_last_row) w_state_next = StRowHdr;
          else                  w_state_next = StFrameEnd;
        end
      end
      StFrameEnd: begin
        o_store_queue_data = 17'h1FFFF;
        o_store_wr_en      = !w_full;
        if (!w_full) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_addr   <= '0;
      r_burst_addr <= '0;
      r_row_idx    <= '0;
      r_burst_idx  <= '0;
      r_off        <= '0;
      r_phase      <= '0;
      r_wcnt       <= '0;
      r_slot       <= '0;
      r_error      <= 1'b0;
      r_armed      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == StFrameEnd) && !w_full;
      if (w_accept) r_error <= w_oob;
      if (r_armed && i_rd_data_valid && (r_state != StReadData)) r_error <= 1'b1;
      if (w_wd_timeout) r_error <= 1'b1;
      unique case (r_state)
        StIdle: if (w_go) begin
          r_row_addr <= w_start_addr;
          r_row_idx  <= '0;
          r_armed    <= 1'b1;
        end
        StRowHdr: if (!w_full) begin
          r_burst_addr <= r_row_addr;
          r_burst_idx  <= '0;
          r_off        <= '0;
          r_phase      <= '0;
        end
        StReadCmd: begin
          r_wcnt <= '0;
          r_slot <= '0;
        end
        StReadData: if (i_rd_data_valid) r_wcnt <= r_wcnt + SLOT_W'(1);
        StDrain: if (w_slot_adv) begin
          r_slot  <= r_slot + SLOT_W'(1);
          r_off   <= r_off + 16'd1;
          r_phase <= (r_phase == 4'(STEP_X - 1)) ? 4'd0 : r_phase + 4'd1;
          if (w_last_slot) begin
            r_burst_idx  <= r_burst_idx + 16'd1;
            r_burst_addr <= r_burst_addr + ADDR_WIDTH'(BURST_PIXELS);
            if (w_last_burst) begin
              r_row_idx  <= r_row_idx + 16'd1;
              r_row_addr <= r_row_addr + ADDR_WIDTH'(ROW_STRIDE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if ((r_state == StReadData) && i_rd_data_valid) begin
      r_buf[w_widx]                <= i_rd_data[15:0];
      r_buf[w_widx | SLOT_W'(1)]   <= i_rd_data[31:16];
    end
  end

  assign o_busy       = (r_state != StIdle);
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;
  assign o_cmd        = 1'b0;

endmodule

// File: tb/tb_frame_window_reader.sv
// Directed bench for frame_window_reader: two instances (unit step and 2x3 decimation) share a
// burst memory model; stream, command count and flags are checked against a reference window.
`timescale 1ns/1ps
module tb_frame_window_reader;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [20:0] base = '0;
  logic [15:0] win_x = '0, win_y = '0;
  logic [31:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  logic        full = 1'b0;

  logic        a_busy, a_done, a_error, a_cmd, a_cmd_en, a_wr_en;
  logic [20:0] a_addr;
  logic [16:0] a_data;
  logic        b_busy, b_done, b_error, b_cmd, b_cmd_en, b_wr_en;
  logic [20:0] b_addr;
  logic [16:0] b_data;

  logic        s_busy, s_done, s_error, s_cmd_en, s_wr_en;
  logic [20:0] s_addr;
  logic [16:0] s_data;

  int          checks = 0, errors = 0;
  int          lat = 0, m_k = -1, cmd_cnt = 0, done_cnt = 0, viol = 0;
  logic        hold_mem = 1'b0, bp_en = 1'b0;
  logic [20:0] m_addr, first_addr;
  logic [16:0] stream_q[$], exp_q[$];

  always #5 clk = ~clk;

  frame_window_reader #(.WATCHDOG_CYCLES(64)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_start(start & ~sel),
    .i_frame_base_addr(base), .i_win_x(win_x), .i_win_y(win_y),
    .o_busy(a_busy), .o_frame_done(a_done), .o_error(a_error), .o_cmd(a_cmd),
    .o_cmd_en(a_cmd_en), .o_addr(a_addr), .i_rd_data(rd_data),
    .i_rd_data_valid(rd_valid & ~sel), .o_store_wr_en(a_wr_en),
    .i_store_queue_full(full & ~sel), .o_store_queue_data(a_data)
  );

  frame_window_reader #(.STEP_X(2), .STEP_Y(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_start(start & sel),
    .i_frame_base_addr(base), .i_win_x(win_x), .i_win_y(win_y),
    .o_busy(b_busy), .o_frame_done(b_done), .o_error(b_error), .o_cmd(b_cmd),
    .o_cmd_en(b_cmd_en), .o_addr(b_addr), .i_rd_data(rd_data),
    .i_rd_data_valid(rd_valid & sel), .o_store_wr_en(b_wr_en),
    .i_store_queue_full(full & sel), .o_store_queue_data(b_data)
  );

  assign s_busy   = sel ? b_busy   : a_busy;
  assign s_done   = sel ? b_done   : a_done;
  assign s_error  = sel ? b_error  : a_error;
  assign s_cmd_en = sel ? b_cmd_en : a_cmd_en;
  assign s_wr_en  = sel ? b_wr_en  : a_wr_en;
  assign s_addr   = sel ? b_addr   : a_addr;
  assign s_data   = sel ? b_data   : a_data;

  function automatic logic [15:0] pix(input logic [20:0] a);
    logic [31:0] t;
    t = {11'd0, a} * 32'h9E3779B1;
    return t[31:16] ^ t[15:0];
  endfunction

  function automatic logic [20:0] win_addr(input logic [20:0] b, input logic [15:0] wx,
                                           input logic [15:0] wy, input int x, input int y);
    logic [31:0] f;
    f = {11'd0, b} + ({16'd0, wy} + 32'(y)) * 32'd640 + {16'd0, wx} + 32'(x);
    return f[20:0];
  endfunction

  // Burst memory: answers each command with BW words after lat idle cycles.
  always begin
    @(negedge clk);
    if (rst_n && s_cmd_en && !hold_mem) begin
      m_addr = s_addr;
      @(negedge clk);
      for (int i = 0; i < lat && rst_n; i++) @(negedge clk);
      for (int k = 0; k < BW; k++) begin
        if (!rst_n) break;
        m_k      = k;
        rd_data  = {pix(m_addr + 21'(2 * k + 1)), pix(m_addr + 21'(2 * k))};
        rd_valid = 1'b1;
        @(negedge clk);
      end
      rd_valid = 1'b0;
      m_k      = -1;
    end
  end

  always @(posedge clk) begin
    #1;
    full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_wr_en) begin
        stream_q.push_back(s_data);
        if (full) viol++;
      end
      if (s_cmd_en) begin
        if (cmd_cnt == 0) first_addr = s_addr;
        cmd_cnt++;
      end
      if (s_done) done_cnt++;
    end
  end

  task automatic build_exp(input logic [20:0] b, input logic [15:0] wx, input logic [15:0] wy,
                           input int sx, input int sy);
    exp_q.delete();
    exp_q.push_back(17'h10000);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(17'h10001);
      for (int j = 0; j < 23; j++) exp_q.push_back({1'b0, pix(win_addr(b, wx, wy, j * sx, i * sy))});
    end
    exp_q.push_back(17'h1FFFF);
  endtask

  task automatic clear_obs();
    stream_q.delete();
    cmd_cnt  = 0;
    done_cnt = 0;
    viol     = 0;
  endtask

  task automatic pulse_start(input logic [20:0] b, input logic [15:0] wx, input logic [15:0] wy);
    @(negedge clk);
    base  = b;
    win_x = wx;
    win_y = wy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stray();
    @(negedge clk);
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input logic s, input logic [20:0] b,
                           input logic [15:0] wx, input logic [15:0] wy,
                           input int sx, input int sy, input int exp_cmd);
    int mism;
    sel = s;
    build_exp(b, wx, wy, sx, sy);
    clear_obs();
    pulse_start(b, wx, wy);
    checks++;
    if (s_busy !== 1'b1 || s_data !== 17'h10000 || s_error !== 1'b0) begin
      errors++;
      $display("FAIL %s start_latency: busy=%b data=%h error=%b, want busy=1 data=10000 error=0",
               nm, s_busy, s_data, s_error);
    end
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s frame_done: pulses=%0d want 1", nm, done_cnt);
    end
    checks++;
    if (stream_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s stream_len: got %0d want %0d", nm, stream_q.size(), exp_q.size());
    end
    mism = -1;
    for (int i = 0; i < stream_q.size() && i < exp_q.size(); i++)
      if (mism < 0 && stream_q[i] !== exp_q[i]) mism = i;
    checks++;
    if (mism >= 0) begin
      errors++;
      $display("FAIL %s stream_word[%0d]: got %h want %h", nm, mism, stream_q[mism], exp_q[mism]);
    end
    checks++;
    if (cmd_cnt != exp_cmd) begin
      errors++;
      $display("FAIL %s cmd_count: got %0d want %0d", nm, cmd_cnt, exp_cmd);
    end
    checks++;
    if (first_addr !== win_addr(b, wx, wy, 0, 0)) begin
      errors++;
      $display("FAIL %s first_addr: got %h want %h", nm, first_addr, win_addr(b, wx, wy, 0, 0));
    end
    checks++;
    if (s_busy !== 1'b0 || s_error !== 1'b0) begin
      errors++;
      $display("FAIL %s end_flags: busy=%b error=%b want 0 0", nm, s_busy, s_error);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_error, a_cmd, a_cmd_en, a_addr, a_wr_en, a_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b err=%b cmd_en=%b addr=%h wr=%b data=%h want all 0",
               a_busy, a_error, a_cmd_en, a_addr, a_wr_en, a_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    pulse_start(21'h0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || stream_q.size() != 0) begin
      errors++;
      $display("FAIL start_without_init: busy=%b writes=%0d want 0 0", a_busy, stream_q.size());
    end
    pulse_stray();
    checks++;
    if (a_error !== 1'b0) begin
      errors++;
      $display("FAIL stray_before_start: error=%b want 0", a_error);
    end
    init_done = 1'b1;
  endtask

  task automatic test_frame_basic();
    lat = 0;
    run_frame("basic", 1'b0, 21'h4B020, 16'd0, 16'd0, 1, 1, 34);
    pulse_stray();
    checks++;
    if (a_error !== 1'b1) begin
      errors++;
      $display("FAIL stray_after_start: error=%b want 1", a_error);
    end
  endtask

  task automatic test_decimation();
    lat = 3;
    run_frame("decim", 1'b1, 21'h01000, 16'd10, 16'd5, 2, 3, 51);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    lat   = 1;
    bp_en = 1'b1;
    run_frame("backpressure", 1'b0, 21'h4B020, 16'd0, 16'd0, 1, 1, 34);
    bp_en = 1'b0;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL wr_while_full: got %0d writes want 0", viol);
    end
  endtask

  task automatic test_bounds();
    sel = 1'b0;
    lat = 0;
    clear_obs();
    pulse_start(21'h4B020, 16'd620, 16'd0);
    checks++;
    if (a_error !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_x: error=%b busy=%b want 1 0", a_error, a_busy);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (cmd_cnt != 0 || stream_q.size() != 0) begin
      errors++;
      $display("FAIL reject_x_traffic: cmd=%0d writes=%0d want 0 0", cmd_cnt, stream_q.size());
    end
    run_frame("edge_wrap", 1'b0, 21'h1F0000, 16'd617, 16'd463, 1, 1, 34);
    clear_obs();
    pulse_start(21'h0, 16'd0, 16'd464);
    repeat (20) @(negedge clk);
    checks++;
    if (a_error !== 1'b1 || cmd_cnt != 0 || stream_q.size() != 0) begin
      errors++;
      $display("FAIL reject_y: error=%b cmd=%0d writes=%0d want 1 0 0",
               a_error, cmd_cnt, stream_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    bit found;
    sel   = 1'b0;
    lat   = 0;
    found = 1'b0;
    pulse_start(21'h4B020, 16'd3, 16'd7);
    for (int c = 0; c < 3000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (rd_valid && m_k == 3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_wait: fourth word seen=%0d want 1", found);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_error, a_cmd, a_cmd_en, a_addr, a_wr_en, a_data} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: busy=%b cmd_en=%b addr=%h wr=%b data=%h want 0",
               a_busy, a_cmd_en, a_addr, a_wr_en, a_data);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame("after_reset", 1'b0, 21'h4B020, 16'd3, 16'd7, 1, 1, 34);
  endtask

`ifdef FRAME_READER_WATCHDOG_EN
  task automatic test_watchdog();
    bit tail;
    sel      = 1'b0;
    hold_mem = 1'b1;
    clear_obs();
    pulse_start(21'h0, 16'd0, 16'd0);
    for (int c = 0; c < 100 && cmd_cnt == 0; c++) @(negedge clk);
    repeat (50) @(negedge clk);
    checks++;
    if (a_error !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_early: error=%b busy=%b want 0 1", a_error, a_busy);
    end
    repeat (20) @(negedge clk);
    tail = 1'b0;
    foreach (stream_q[i]) if (stream_q[i] === 17'h1FFFF) tail = 1'b1;
    checks++;
    if (a_error !== 1'b1 || a_busy !== 1'b0 || tail) begin
      errors++;
      $display("FAIL watchdog_timeout: error=%b busy=%b end_marker=%b want 1 0 0",
               a_error, a_busy, tail);
    end
    hold_mem = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_basic();
    test_decimation();
    test_backpressure();
    test_bounds();
    test_reset_midframe();
`ifdef FRAME_READER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
